johnson_decoder: RTL and testbench
==================================

# johnson_decoder

Receive-side companion to the team's twisted-ring (Johnson) counter. Samples a WIDTH-bit Johnson code each valid cycle and decodes it to a binary state index. Flags non-Johnson patterns and out-of-sequence steps, and tracks lock to the counter's sequence. Sits downstream of a twisted-ring counter, or of any link carrying its state, as a decoder and integrity monitor.

## Interface
- WIDTH, 4: Johnson code width; sequence length is 2*WIDTH states; WIDTH >= 2.
- LOCK_CNT, 3: consecutive correct successor steps required to enter LOCKED; 1..15.
- IW (localparam), $clog2(2*WIDTH): index width.
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_code is sampled this cycle.
- in_code  input  WIDTH  Johnson code under test.
- err_clr  input  1  pulse; clears err_count.
- out_valid  output  1  registered copy of in_valid.
- out_index  output  IW  decoded index 0..2*WIDTH-1.
- illegal  output  1  sampled code is not a Johnson pattern.
- seq_err  output  1  legal code, but not the successor of the previous sample, while LOCKED.
- locked  output  1  decoder is in LOCKED.
- err_count  output  8  saturating error counter.

## Operation
- Sequence, matching the counter's shift-right / invert-LSB-into-MSB rule from 0: index k for 0..WIDTH has its top k bits set (0000, 1000, 1100, 1110, 1111). Index WIDTH+j for 1..WIDTH-1 has its top j bits clear and the rest set (0111, 0011, 0001).
- Legal iff the code is ones-then-zeros or zeros-then-ones reading from the MSB.
- Decode: p = popcount(in_code).
  - MSB=1 or code all-zero: index = p.
  - Otherwise: index = (2*WIDTH - p) mod 2*WIDTH.
- Illegal code: out_index = 0, illegal = 1.
- Successor: (prev + 1) mod 2*WIDTH. Wrap from 2*WIDTH-1 to 0 is a legal step.
- Only valid samples update state; gaps in in_valid are stalls, not errors.
- FSM, 2 states, held in the prev register and a consecutive-step counter:
  - UNLOCKED:
    - legal successor of prev increments consec; consec reaching LOCK_CNT goes to LOCKED.
    - any other legal code reloads prev and sets consec = 0.
    - illegal clears prev-valid and sets consec = 0.
    - seq_err is never asserted in UNLOCKED.
  - LOCKED:
    - correct successor: stay.
    - illegal: assert illegal, go to UNLOCKED, consec = 0.
    - wrong legal code: assert seq_err, go to UNLOCKED, prev = new code, consec = 0.
- The first valid sample after reset only loads prev.
- err_count increments by 1 on each output cycle where illegal | seq_err, and saturates at 255.
  - err_clr sets it to 0; clear wins over a simultaneous increment.

## Timing
- Reset values:
  - Outputs: out_valid = 0, out_index = 0, illegal = 0, seq_err = 0, locked = 0, err_count = 0.
  - Internal: FSM in UNLOCKED, prev-valid = 0, consec = 0.
- Latency 1: the sample at edge N appears on all outputs after edge N. out_valid, illegal and seq_err are single-cycle per sample.
- out_index holds its value while out_valid = 0. illegal and seq_err are 0 when out_valid = 0.
- locked rises in the cycle that reports the LOCK_CNT-th correct step, and falls in the cycle reporting the error.
- rstn low mid-stream: next edge returns everything to reset values; in-flight sample discarded.

## Configuration
- JOHNSON_DEC_ERRCNT_EN:
  - Defined: err_count and err_clr behave as above.
  - Undefined: counter logic is omitted, err_count is tied to 0, err_clr is ignored. All other behaviour is unchanged.

## Structure
- Package johnson_pkg:
  - decoder state enum (UNLOCKED, LOCKED).
  - err_count width constant (8) and its saturation value (255).
- Sub-module johnson_code_check: purely combinational; WIDTH in; outputs legal and index. Reusable by other Johnson-code consumers.
- Top holds the FSM, prev/consec registers, output registers and the optional counter.

## Test plan
- Reset, then 9 valid samples 0000,1000,1100,1110,1111,0111,0011,0001,0000:
  - indices 0..7 then 0, no errors.
  - locked = 1 on the output cycle of the 4th sample (1110).
- Locked, then 1010 -> illegal = 1, out_index = 0, locked = 0, err_count = 1.
- Locked at 1100, then 1111 -> seq_err = 1, out_index = 4, locked = 0.
  - Then 0111, 0011, 0001 -> relock on 0001.
- Locked stream with in_valid low for 5 cycles mid-sequence -> out_valid = 0, no errors; lock held on resume.
- 260 illegal samples -> err_count stops at 255.
  - err_clr in the same cycle as an error output -> err_count = 0.
- Assert rstn low for 1 cycle mid-stream while locked -> all outputs 0 next cycle.
  - Relock needs a fresh load plus LOCK_CNT steps.

Source files
------------

// File: rtl/johnson_pkg.sv
// johnson_pkg
//   Shared types and constants for the Johnson (twisted-ring) code consumers.
//   - dec_state_e : lock state of johnson_decoder (UNLOCKED / LOCKED)
//   - ERR_CNT_W   : width of the saturating error counter
//   - ERR_CNT_MAX : saturation value of the error counter
package johnson_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } dec_state_e;

  localparam int unsigned           ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0]  ERR_CNT_MAX = '1;

endpackage

// File: rtl/johnson_code_check.sv
// johnson_code_check
//   Purely combinational Johnson-code checker and decoder.
//   Ports:
//     code  [WIDTH-1:0]  in   code under test
//     legal              out  code is ones-then-zeros or zeros-then-ones from MSB
//     index [IW-1:0]     out  decoded state index 0..2*WIDTH-1 (0 when illegal)
//   Parameters:
//     WIDTH  code width (>= 2); IW = $clog2(2*WIDTH)
module johnson_code_check #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IW    = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [IW-1:0]    index
);

  int unsigned pop;
  int unsigned trans;

  // A Johnson pattern has at most one boundary between adjacent bits.
  always_comb begin
    pop   = 0;
    trans = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (code[i]) pop++;
    end
    for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
      if (code[i] != code[i+1]) trans++;
    end
    legal = (trans <= 1);
    index = '0;
    if (legal) begin
      if (code[WIDTH-1] || pop == 0) index = IW'(pop);
      else                           index = IW'(2*WIDTH - pop);
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// johnson_decoder
//   Samples a Johnson code on each valid cycle, decodes it to a state index,
//   flags illegal patterns and out-of-sequence steps, and tracks lock to the
//   counter sequence. All outputs are registered (latency 1).
//   Ports:
//     clk, rstn (sync, active-low)
//     in_valid, in_code[WIDTH-1:0]   sample input
//     err_clr                        clears err_count (wins over increment)
//     out_valid, out_index[IW-1:0]   registered sample result
//     illegal, seq_err               per-sample error flags
//     locked                         decoder is in LOCKED
//     err_count[7:0]                 saturating error count
//   Build option: define JOHNSON_DEC_ERRCNT_EN to include the error counter;
//   otherwise err_count is tied to 0 and err_clr is ignored.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter  int unsigned WIDTH    = 4,
  parameter  int unsigned LOCK_CNT = 3,
  localparam int unsigned IW       = $clog2(2*WIDTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_code,
  input  logic                 err_clr,
  output logic                 out_valid,
  output logic [IW-1:0]        out_index,
  output logic                 illegal,
  output logic                 seq_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [IW-1:0] LAST_IDX = IW'(2*WIDTH - 1);
  localparam logic [3:0]    LOCK_TGT = 4'(LOCK_CNT);

  logic          code_legal;
  logic [IW-1:0] code_idx;

  johnson_code_check #(.WIDTH(WIDTH)) u_check (
    .code  (in_code),
    .legal (code_legal),
    .index (code_idx)
  );

  dec_state_e    state_q, state_d;
  logic [IW-1:0] prev_q, prev_d;
  logic          prev_vld_q, prev_vld_d;
  logic [3:0]    consec_q, consec_d;
  logic          out_valid_q, out_valid_d;
  logic [IW-1:0] out_index_q, out_index_d;
  logic          illegal_q, illegal_d;
  logic          seq_err_q, seq_err_d;
  logic          locked_q, locked_d;

  logic [IW-1:0] succ_idx;
  logic          is_succ;

  assign succ_idx = (prev_q == LAST_IDX) ? '0 : prev_q + IW'(1);
  assign is_succ  = prev_vld_q && code_legal && (code_idx == succ_idx);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    consec_d    = consec_q;
    out_valid_d = in_valid;
    out_index_d = out_index_q;
    illegal_d   = 1'b0;
    seq_err_d   = 1'b0;
    if (in_valid) begin
      out_index_d = code_idx;
      if (!code_legal) begin
        illegal_d  = 1'b1;
        prev_vld_d = 1'b0;
        consec_d   = '0;
        state_d    = UNLOCKED;
      end else begin
        prev_d     = code_idx;
        prev_vld_d = 1'b1;
        case (state_q)
          UNLOCKED: begin
            if (is_succ) begin
              consec_d = consec_q + 4'd1;
              if (consec_d == LOCK_TGT) state_d = LOCKED;
            end else begin
              consec_d = '0;
            end
          end
          LOCKED: begin
            if (!is_succ) begin
              seq_err_d = 1'b1;
              consec_d  = '0;
              state_d   = UNLOCKED;
            end
          end
          default: state_d = UNLOCKED;
        endcase
      end
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= UNLOCKED;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      consec_q    <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      consec_q    <= consec_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      illegal_q   <= illegal_d;
      seq_err_q   <= seq_err_d;
      locked_q    <= locked_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign illegal   = illegal_q;
  assign seq_err   = seq_err_q;
  assign locked    = locked_q;

`ifdef JOHNSON_DEC_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counter advances on the same edge that registers the error flags, so the
  // new count is visible in the error's output cycle.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr)
      err_cnt_d = '0;
    else if ((illegal_d || seq_err_d) && err_cnt_q != ERR_CNT_MAX)
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
module tb_johnson_decoder;

  localparam int unsigned W  = 4;
  localparam int unsigned LC = 3;
  localparam int unsigned N  = 2*W;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned VW = IW + 12;
`ifdef JOHNSON_DEC_ERRCNT_EN
  localparam bit ERRCNT_EN = 1'b1;
`else
  localparam bit ERRCNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic [W-1:0]  in_code;
  logic          err_clr;
  logic          out_valid;
  logic [IW-1:0] out_index;
  logic          illegal;
  logic          seq_err;
  logic          locked;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  johnson_decoder #(.WIDTH(W), .LOCK_CNT(LC)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .err_clr   (err_clr),
    .out_valid (out_valid),
    .out_index (out_index),
    .illegal   (illegal),
    .seq_err   (seq_err),
    .locked    (locked),
    .err_count (err_count)
  );

  logic [VW-1:0] dut_vec;
  assign dut_vec = {out_valid, out_index, illegal, seq_err, locked, err_count};

  int compared   = 0;
  int mismatched = 0;

  // Reference sequence: index k's code, built from the counter's rule.
  logic [W-1:0] seq_tab [N];

  // Behavioural model state
  bit m_pv, m_locked, e_valid, e_ill, e_seq;
  int m_prev, m_consec, m_cnt, e_idx;

  function automatic int lookup(input logic [W-1:0] c);
    for (int k = 0; k < N; k++) if (seq_tab[k] == c) return k;
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_illegal();
    logic [W-1:0] c;
    do c = W'($urandom); while (lookup(c) >= 0);
    return c;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [7:0] cnt;
    cnt = ERRCNT_EN ? 8'(m_cnt) : 8'd0;
    return {e_valid, IW'(e_idx), e_ill, e_seq, m_locked, cnt};
  endfunction

  task automatic model_reset();
    m_pv = 0; m_locked = 0; m_prev = 0; m_consec = 0; m_cnt = 0;
    e_valid = 0; e_ill = 0; e_seq = 0; e_idx = 0;
  endtask

  // Apply one cycle of inputs, then advance the model to match.
  task automatic drive(input bit rst_n, input bit v, input bit clr, input logic [W-1:0] c);
    int  k;
    bit  succ;
    rstn = rst_n; in_valid = v; err_clr = clr; in_code = c;
    @(posedge clk); #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      e_valid = v; e_ill = 0; e_seq = 0;
      if (v) begin
        k = lookup(c);
        if (k < 0) begin
          e_ill = 1; e_idx = 0; m_pv = 0; m_consec = 0; m_locked = 0;
        end else begin
          succ = m_pv && (k == (m_prev + 1) % N);
          if (m_locked) begin
            if (!succ) begin e_seq = 1; m_locked = 0; m_consec = 0; end
          end else if (succ) begin
            m_consec++;
            if (m_consec == LC) m_locked = 1;
          end else begin
            m_consec = 0;
          end
          m_prev = k; m_pv = 1; e_idx = k;
        end
      end
      if (clr) m_cnt = 0;
      else if ((e_ill || e_seq) && m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, W'($urandom));
      compared++;
      if (dut_vec !== '0) begin
        mismatched++;
        $display("FAIL reset: got %b want %b", dut_vec, {VW{1'b0}});
      end
    end
  endtask

  task automatic test_sequence();
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 0, seq_tab[i % N]);
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL sequence[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
      compared++;
      if (out_index !== IW'(i % N) || locked !== (i >= 3) || illegal !== 1'b0 || seq_err !== 1'b0) begin
        mismatched++;
        $display("FAIL sequence_idx[%0d]: got idx=%0d lk=%b want idx=%0d lk=%b", i, out_index, locked, i % N, i >= 3);
      end
    end
  endtask

  task automatic test_illegal();
    drive(1, 1, 0, 4'b1010);
    compared++;
    if (dut_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL illegal: got %b want %b", dut_vec, exp_vec());
    end
    compared++;
    if (illegal !== 1'b1 || out_index !== '0 || locked !== 1'b0 || err_count !== (ERRCNT_EN ? 8'd1 : 8'd0)) begin
      mismatched++;
      $display("FAIL illegal_flags: got ill=%b idx=%0d lk=%b cnt=%0d want 1 0 0 %0d", illegal, out_index, locked, err_count, ERRCNT_EN ? 1 : 0);
    end
  endtask

  task automatic test_seq_err();
    logic [W-1:0] pre  [4] = '{4'b0001, 4'b0000, 4'b1000, 4'b1100};
    logic [W-1:0] post [3] = '{4'b0111, 4'b0011, 4'b0001};
    foreach (pre[i]) drive(1, 1, 0, pre[i]);
    compared++;
    if (locked !== 1'b1 || dut_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL seq_lock: got %b want %b", dut_vec, exp_vec());
    end
    drive(1, 1, 0, 4'b1111);
    compared++;
    if (seq_err !== 1'b1 || out_index !== IW'(4) || locked !== 1'b0 || illegal !== 1'b0) begin
      mismatched++;
      $display("FAIL seq_err: got se=%b idx=%0d lk=%b want 1 4 0", seq_err, out_index, locked);
    end
    foreach (post[i]) begin
      drive(1, 1, 0, post[i]);
      compared++;
      if (locked !== (i == 2) || dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL relock[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    logic [IW-1:0] held;
    for (int i = 0; i < 2; i++) drive(1, 1, 0, seq_tab[(m_prev + 1) % N]);
    held = out_index;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, W'($urandom));
      compared++;
      if (out_valid !== 1'b0 || illegal !== 1'b0 || seq_err !== 1'b0 || locked !== 1'b1
          || out_index !== held || dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL stall[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, seq_tab[(m_prev + 1) % N]);
      compared++;
      if (locked !== 1'b1 || dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL stall_resume[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      drive(1, 1, 0, rand_illegal());
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL saturate[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
    end
    compared++;
    if (err_count !== (ERRCNT_EN ? 8'd255 : 8'd0)) begin
      mismatched++;
      $display("FAIL saturate_cap: got %0d want %0d", err_count, ERRCNT_EN ? 255 : 0);
    end
    drive(1, 1, 1, rand_illegal());
    compared++;
    if (illegal !== 1'b1 || err_count !== 8'd0 || dut_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL clear_wins: got ill=%b cnt=%0d want 1 0", illegal, err_count);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    k = $urandom_range(0, N-1);
    drive(1, 1, 0, seq_tab[k]);
    for (int i = 0; i < LC; i++) drive(1, 1, 0, seq_tab[(m_prev + 1) % N]);
    compared++;
    if (locked !== 1'b1 || dut_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL prereset_lock: got %b want %b", dut_vec, exp_vec());
    end
    drive(0, 1, 0, seq_tab[(m_prev + 1) % N]);
    compared++;
    if (dut_vec !== '0) begin
      mismatched++;
      $display("FAIL reset_mid: got %b want %b", dut_vec, {VW{1'b0}});
    end
    // After reset the first valid sample only loads; any earlier prev is gone.
    k = $urandom_range(0, N-1);
    drive(1, 1, 0, seq_tab[k]);
    for (int i = 0; i <= LC; i++) begin
      compared++;
      if (locked !== (i == LC) || dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL relock_after_reset[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
      if (i < LC) drive(1, 1, 0, seq_tab[(k + i + 1) % N]);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 60) drive(1, 1, 0, seq_tab[(m_prev + 1) % N]);
      else if (r < 72) drive(1, 1, 0, seq_tab[$urandom_range(0, N-1)]);
      else if (r < 82) drive(1, 1, 0, rand_illegal());
      else if (r < 92) drive(1, 0, 0, W'($urandom));
      else if (r < 98) drive(1, $urandom_range(0, 1) == 1, 1, W'($urandom));
      else             drive(0, 1, 0, W'($urandom));
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL random[%0d]: got %b want %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      if (k <= W) seq_tab[k] = W'(((1 << k) - 1) << (W - k));
      else        seq_tab[k] = W'((1 << (2*W - k)) - 1);
    end
    model_reset();
    rstn = 0; in_valid = 0; err_clr = 0; in_code = '0;
    test_reset();
    test_sequence();
    test_illegal();
    test_seq_err();
    test_stall();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
